// File: rtl/ovengame_pkg.sv
// Shared definitions for the "forno" reaction minigame.
package ovengame_pkg;

    // FSM state codes; the numeric values are shown on the debug display.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP   = 3'd1,
        ST_ESPERA = 3'd2,
        ST_SHOW   = 3'd3,
        ST_ACERTO = 3'd4,
        ST_ERRO   = 3'd5,
        ST_PROX   = 3'd6,
        ST_FIM    = 3'd7
    } state_t;

    // Feedback taps of the 8-bit Fibonacci LFSR: bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Console game-select code for this game (fourth slot of the selector).
    localparam logic [1:0] GAME_FORNO = 2'd3;

    // Target derived from the LFSR low bits; 0 is not a valid target and maps to 7.
    function automatic logic [2:0] alvo_map(input logic [2:0] raw);
        alvo_map = (raw == 3'd0) ? 3'd7 : raw;
    endfunction

    // Button vector that counts as a hit for target t (1..7).
    function automatic logic [6:0] alvo_onehot(input logic [2:0] t);
        alvo_onehot = 7'b1 << (t - 3'd1);
    endfunction

endpackage

// File: rtl/ovengame_gerador_alvo.sv
// Target generator: free-running LFSR plus capture of the next target 1..7.
module ovengame_gerador_alvo
    import ovengame_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_in,
    input  logic       latch,
    output logic [2:0] alvo
);

    logic [7:0] lfsr;

    // LFSR advances every cycle regardless of game state, so the target depends on timing.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) lfsr <= SEED;
        else           lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end

    // Capture the target on the last ESPERA cycle; it stays stable through SHOW.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in)  alvo <= 3'd0;
        else if (latch) alvo <= alvo_map(lfsr[2:0]);
    end

endmodule

// File: rtl/ovengame.sv
// "forno" reaction minigame: responder side of the console start/finish handshake.
module ovengame
    import ovengame_pkg::*;
#(
    parameter int         TIMER_W      = 16,
    parameter int         TIMEOUT_EASY = 1000,
    parameter int         TIMEOUT_HARD = 500,
    parameter int         GAP          = 200,
    parameter int         ROUNDS       = 7,
    parameter logic [7:0] SEED         = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_in,
    input  logic       jogar,
    input  logic       dificuldade,
    input  logic [6:0] botoes,
    output logic [3:0] estado,
    output logic [6:0] jogadas,
    output logic [2:0] leds,
    output logic [2:0] pontuacao,
    output logic       pronto
);

    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP - 1);
    localparam logic [TIMER_W-1:0] EASY_LAST = TIMER_W'(TIMEOUT_EASY - 1);
    localparam logic [TIMER_W-1:0] HARD_LAST = TIMER_W'(TIMEOUT_HARD - 1);
    localparam logic [2:0]         RND_LAST  = 3'(ROUNDS);

    state_t             st;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] tmo_last;
    logic [2:0]         rodada;
    logic               dif_q;
    logic [6:0]         b_q, b_prev, borda;
    logic [2:0]         alvo;
    logic               latch;

    assign tmo_last = dif_q ? HARD_LAST : EASY_LAST;
    assign borda    = b_q & ~b_prev;
    // A restart request overrides the ESPERA exit, so no target is captured then.
    assign latch    = (st == ST_ESPERA) && (timer == GAP_LAST) && !jogar;

    // Outputs are pure decodes of registers; nothing reaches them from the inputs directly.
    assign estado = {1'b0, st};
    assign leds   = (st == ST_SHOW) ? alvo : 3'd0;

    ovengame_gerador_alvo #(.SEED(SEED)) u_alvo (
        .clock    (clock),
        .reset_in (reset_in),
        .latch    (latch),
        .alvo     (alvo)
    );

    // Button history for rising-edge detection; buttons held from before SHOW give no edge.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            b_q    <= 7'd0;
            b_prev <= 7'd0;
        end else begin
            b_q    <= botoes;
            b_prev <= b_q;
        end
    end

    // Game FSM with round timer, score and handshake outputs; jogar wins over everything.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            st        <= ST_IDLE;
            timer     <= '0;
            rodada    <= 3'd0;
            dif_q     <= 1'b0;
            jogadas   <= 7'd0;
            pontuacao <= 3'd0;
            pronto    <= 1'b0;
        end else if (jogar) begin
            st        <= ST_PREP;
            timer     <= '0;
            rodada    <= 3'd0;
            dif_q     <= dificuldade;
            jogadas   <= 7'd0;
            pontuacao <= 3'd0;
            pronto    <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    st <= ST_IDLE;
                end
                ST_PREP: begin
                    st    <= ST_ESPERA;
                    timer <= '0;
                end
                ST_ESPERA: begin
                    if (timer == GAP_LAST) begin
                        st    <= ST_SHOW;
                        timer <= '0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_SHOW: begin
                    // A press on the timeout cycle still counts as a press.
                    if (borda != 7'd0) begin
                        jogadas <= borda;
                        st      <= (borda == alvo_onehot(alvo)) ? ST_ACERTO : ST_ERRO;
                        timer   <= '0;
                    end else if (timer == tmo_last) begin
                        st    <= ST_ERRO;
                        timer <= '0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_ACERTO: begin
                    if (pontuacao != 3'd7) pontuacao <= pontuacao + 3'd1;
                    st <= ST_PROX;
                end
                ST_ERRO: begin
                    st <= ST_PROX;
                end
                ST_PROX: begin
                    rodada <= rodada + 3'd1;
                    if (rodada + 3'd1 == RND_LAST) begin
                        st     <= ST_FIM;
                        pronto <= 1'b1;
                    end else begin
                        st      <= ST_ESPERA;
                        jogadas <= 7'd0;
                    end
                end
                ST_FIM: begin
                    st <= ST_FIM;
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ovengame.sv
// Self-checking bench for the forno minigame: directed round table plus randomized games.
module tb_ovengame;

    localparam int GAP  = 200;
    localparam int T_EZ = 1000;
    localparam int T_HD = 500;

    // round actions
    localparam int A_OK    = 0;
    localparam int A_WRONG = 1;
    localparam int A_MULTI = 2;
    localparam int A_TMO   = 3;
    localparam int A_HELD  = 4;
    localparam int A_ABORT = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       jogar = 1'b0;
    logic       dificuldade = 1'b0;
    logic [6:0] botoes = 7'd0;
    logic [3:0] estado;
    logic [6:0] jogadas;
    logic [2:0] leds;
    logic [2:0] pontuacao;
    logic       pronto;

    int n_pass = 0;
    int n_tot  = 0;

    logic [7:0] m_lfsr;

    typedef struct {
        int act;
        int dly;
        int exp_st;
        int exp_score;
    } vec_t;

    vec_t tbl [7];

    ovengame dut (
        .clock       (clk),
        .reset_in    (rst_n),
        .jogar       (jogar),
        .dificuldade (dificuldade),
        .botoes      (botoes),
        .estado      (estado),
        .jogadas     (jogadas),
        .leds        (leds),
        .pontuacao   (pontuacao),
        .pronto      (pronto)
    );

    always #5 clk = ~clk;

    // Reference LFSR: advances once per clock out of reset, from the seed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_tot++;
        if (got != exp) $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        else            n_pass++;
    endtask

    function automatic logic [2:0] tmap(input logic [7:0] l);
        tmap = (l[2:0] == 3'd0) ? 3'd7 : l[2:0];
    endfunction

    function automatic logic [6:0] oh(input logic [2:0] t);
        oh = 7'b1 << (t - 3'd1);
    endfunction

    // Pulse jogar; expects PREP with cleared outputs, leaves us on the first ESPERA cycle.
    task automatic start_game(input int diff);
        botoes      = 7'd0;
        jogar       = 1'b1;
        dificuldade = diff[0];
        @(negedge clk);
        chk("prep_state", estado, 1);
        chk("prep_score", pontuacao, 0);
        chk("prep_pronto", pronto, 0);
        chk("prep_jogadas", jogadas, 0);
        jogar       = 1'b0;
        dificuldade = ~diff[0];   // must be ignored from now on
        @(negedge clk);
        chk("prep_to_espera", estado, 2);
    endtask

    // One round starting at the first ESPERA cycle; ends on the verdict cycle (or SHOW entry for abort).
    task automatic play_round(input int act, input int dly, input int tmo, input int exp_st);
        logic [2:0] t;
        logic [6:0] pv;
        t  = 3'd0;
        pv = 7'd0;
        if (act == A_HELD) botoes = 7'h7F;
        for (int i = 0; i < GAP; i++) begin
            if (i == 0 || i == GAP - 1) chk("espera", estado, 2);
            if (i == GAP - 1) t = tmap(m_lfsr);
            @(negedge clk);
        end
        chk("show_entry", estado, 3);
        chk("leds_target", leds, t);
        if (act == A_ABORT) return;
        if (act == A_OK || act == A_WRONG || act == A_MULTI) begin
            if (act == A_OK)         pv = oh(t);
            else if (act == A_WRONG) pv = oh((t == 3'd7) ? 3'd1 : t + 3'd1);
            else                     pv = oh(t) | ((t == 3'd1) ? 7'b0000010 : 7'b0000001);
            repeat (dly) @(negedge clk);
            botoes = pv;
            @(negedge clk);
            chk("show_before_verdict", estado, 3);
            @(negedge clk);
            chk("verdict", estado, exp_st);
            chk("jogadas", jogadas, pv);
            botoes = 7'd0;
        end else begin
            repeat (tmo - 1) @(negedge clk);
            chk("show_last_cycle", estado, 3);
            @(negedge clk);
            chk("timeout_verdict", estado, exp_st);
            chk("timeout_jogadas", jogadas, 0);
            botoes = 7'd0;
        end
    endtask

    // PROX then either the next ESPERA or FIM.
    task automatic end_round(input int last, input int exp_score);
        @(negedge clk);
        chk("prox", estado, 6);
        chk("score", pontuacao, exp_score);
        @(negedge clk);
        chk("after_prox", estado, (last != 0) ? 7 : 2);
        chk("pronto", pronto, last);
        if (last == 0) chk("jogadas_cleared", jogadas, 0);
        else           chk("fim_leds", leds, 0);
    endtask

    // Randomized game against the score model.
    task automatic random_game(input int diff, input int first_act);
        int sc, act, tmo;
        sc  = 0;
        tmo = (diff != 0) ? T_HD : T_EZ;
        start_game(diff);
        for (int r = 0; r < 7; r++) begin
            act = (r == 0 && first_act >= 0) ? first_act : int'($urandom_range(0, 4));
            play_round(act, int'($urandom_range(0, 60)), tmo, (act == A_OK) ? 4 : 5);
            if (act == A_OK) sc = (sc == 7) ? 7 : sc + 1;
            end_round((r == 6) ? 1 : 0, sc);
        end
    endtask

    initial begin
        int bad;
        int sc;

        tbl[0] = '{A_OK,    0,        4, 1};
        tbl[1] = '{A_WRONG, 3,        5, 1};
        tbl[2] = '{A_MULTI, 0,        5, 1};
        tbl[3] = '{A_TMO,   0,        5, 1};
        tbl[4] = '{A_OK,    T_EZ - 2, 4, 2};   // press lands on the timeout cycle
        tbl[5] = '{A_HELD,  0,        5, 2};
        tbl[6] = '{A_OK,    5,        4, 3};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_estado", estado, 0);
        chk("rst_leds", leds, 0);
        chk("rst_score", pontuacao, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_jogadas", jogadas, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_hold", estado, 0);

        // directed table game, easy
        start_game(0);
        for (int r = 0; r < 7; r++) begin
            play_round(tbl[r].act, tbl[r].dly, T_EZ, tbl[r].exp_st);
            end_round((r == 6) ? 1 : 0, tbl[r].exp_score);
        end

        // all hits, then FIM held
        start_game(0);
        for (int r = 0; r < 7; r++) begin
            play_round(A_OK, int'($urandom_range(0, 40)), T_EZ, 4);
            end_round((r == 6) ? 1 : 0, r + 1);
        end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (estado != 4'd7 || pronto != 1'b1 || pontuacao != 3'd7) bad++;
        end
        chk("fim_hold_bad_cycles", bad, 0);

        // restart in SHOW of round 4, then a hard game opening with a timeout
        start_game(0);
        sc = 0;
        for (int r = 0; r < 3; r++) begin
            play_round(A_OK, 2, T_EZ, 4);
            sc++;
            end_round(0, sc);
        end
        play_round(A_ABORT, 0, T_EZ, 3);
        random_game(1, A_TMO);

        random_game(int'($urandom_range(0, 1)), -1);
        random_game(int'($urandom_range(0, 1)), -1);

        // async reset in the middle of SHOW
        start_game(0);
        play_round(A_ABORT, 0, T_EZ, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_estado", estado, 0);
        chk("midrst_leds", leds, 0);
        chk("midrst_score", pontuacao, 0);
        chk("midrst_pronto", pronto, 0);
        chk("midrst_jogadas", jogadas, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", estado, 0);
        start_game(0);
        play_round(A_OK, 1, T_EZ, 4);
        end_round(0, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
